// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder and its word array.
package dmem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_LATENCY_DEFAULT    = 2;
  localparam int DMEM_DEPTH_LOG2_DEFAULT = 8;

  // Countdown preload at acceptance: one count per WAIT cycle still to come
  function automatic logic [3:0] cnt_preload(input int latency);
    return 4'(latency - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage behind the responder: synchronous write, combinational read,
// and every word cleared while reset is held.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  localparam int WORDS = 2 ** DEPTH_LOG2;

  logic [15:0] mem [WORDS];

  // Clear the whole array on reset, otherwise commit one word when enabled
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= 16'h0000;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_stall_responder.sv
// Multi-cycle data memory for the memory stage: accepts one word request, holds the
// requester with Stall for LATENCY cycles, then pulses Done with read data or commits
// the write on the edge that ends the Done cycle.
module dmem_stall_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2_DEFAULT,
  parameter int LATENCY    = DMEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Enable,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        Busy,
  output logic        Err
);

  dmem_state_t           state;
  logic [3:0]            cnt;
  logic                  capWr;
  logic                  capOdd;
  logic [DEPTH_LOG2-1:0] capWord;
  logic [15:0]           capData;
  logic                  doneReg;
  logic                  errReg;
  logic                  memWe;
  logic [15:0]           memRdata;
  logic                  unusedAddr;

  // Responder FSM: capture the request, count down the latency, then respond for one
  // cycle; WAIT is left as the count reaches zero so Done lands LATENCY cycles after
  // acceptance, and Done/Err are registered alongside the move into RESP
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      capWr   <= 1'b0;
      capOdd  <= 1'b0;
      capWord <= '0;
      capData <= 16'h0000;
      doneReg <= 1'b0;
      errReg  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      errReg  <= 1'b0;
      case (state)
        IDLE: begin
          if (Enable) begin
            capWr   <= Wr;
            capOdd  <= Addr[0];
            capWord <= Addr[DEPTH_LOG2:1];
            capData <= DataIn;
            cnt     <= cnt_preload(LATENCY);
            if (LATENCY == 1) begin
              state   <= RESP;
              doneReg <= 1'b1;
              errReg  <= Addr[0];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= RESP;
            doneReg <= 1'b1;
            errReg  <= capOdd;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign memWe = (state == RESP) & capWr & ~capOdd;

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (memWe),
    .addr (capWord),
    .wdata(capData),
    .rdata(memRdata)
  );

  assign Done       = doneReg;
  assign Err        = errReg;
  assign DataOut    = (doneReg & ~errReg) ? memRdata : 16'h0000;
  assign Stall      = Enable & ~doneReg;
  assign Busy       = (state != IDLE);
  assign unusedAddr = ^Addr;

endmodule

// File: tb/tb_dmem_stall_responder.sv
// Bench for dmem_stall_responder: three instances (LATENCY 2, 1 and 4) run directed
// scenarios and random traffic, checked every cycle against a timeline model that
// records when each request was accepted and when it must complete.
module tb_dmem_stall_responder;

  localparam int NI = 3;

  logic        clk = 1'b1;
  logic        rst   [NI];
  logic        en    [NI];
  logic        wr    [NI];
  logic [15:0] addr  [NI];
  logic [15:0] din   [NI];
  logic [15:0] dout  [NI];
  logic        done  [NI];
  logic        stall [NI];
  logic        busy  [NI];
  logic        err   [NI];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit          valid   [NI];
  int          acceptC [NI];
  int          doneC   [NI];
  bit          mWr     [NI];
  bit          mOdd    [NI];
  int          mWord   [NI];
  logic [15:0] mData   [NI];
  logic [15:0] mem     [NI][256];

  always #5 clk = ~clk;

  dmem_stall_responder #(.DEPTH_LOG2(8), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst[0]), .Enable(en[0]), .Wr(wr[0]), .Addr(addr[0]), .DataIn(din[0]),
    .DataOut(dout[0]), .Done(done[0]), .Stall(stall[0]), .Busy(busy[0]), .Err(err[0]));

  dmem_stall_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst[1]), .Enable(en[1]), .Wr(wr[1]), .Addr(addr[1]), .DataIn(din[1]),
    .DataOut(dout[1]), .Done(done[1]), .Stall(stall[1]), .Busy(busy[1]), .Err(err[1]));

  dmem_stall_responder #(.DEPTH_LOG2(8), .LATENCY(4)) u2 (
    .clk(clk), .rst(rst[2]), .Enable(en[2]), .Wr(wr[2]), .Addr(addr[2]), .DataIn(din[2]),
    .DataOut(dout[2]), .Done(done[2]), .Stall(stall[2]), .Busy(busy[2]), .Err(err[2]));

  function automatic int latOf(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int k, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s inst%0d got=%h want=%h cycle=%0d", name, k, actual, expected, cyc);
    end
  endtask

  // Watch instance k from the current cycle until Done, counting cycles and Stall cycles
  task automatic waitDone(input int k, output int lat, output int stalls,
                          output logic [15:0] rd, output logic er);
    bit got;
    got    = 0;
    lat    = 0;
    stalls = 0;
    rd     = 16'h0000;
    er     = 1'b0;
    while (!got && lat <= 20) begin
      @(negedge clk);
      if (stall[k] === 1'b1) stalls++;
      if (done[k] === 1'b1) begin
        got = 1;
        rd  = dout[k];
        er  = err[k];
      end else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    if (!got) checkOutput("timeout", k, 16'd0, 16'd1);
  endtask

  // Issue one request on instance k, wait for its Done, then drop Enable
  task automatic applyStimulus(input int k, input logic w, input logic [15:0] a,
                               input logic [15:0] d, output int lat, output int stalls,
                               output logic [15:0] rd, output logic er);
    @(posedge clk);
    #1;
    en[k]   = 1'b1;
    wr[k]   = w;
    addr[k] = a;
    din[k]  = d;
    waitDone(k, lat, stalls, rd, er);
    @(posedge clk);
    #1;
    en[k] = 1'b0;
  endtask

  // Per-cycle compare against the timeline model, then advance the model with the
  // inputs the DUT will sample at the coming rising edge
  always @(negedge clk) begin
    logic        expDone;
    logic        expBusy;
    logic        expErr;
    logic [15:0] expData;
    for (int k = 0; k < NI; k++) begin
      if (valid[k]) begin
        expDone = (doneC[k] == cyc);
        expBusy = (acceptC[k] < cyc) && (cyc <= doneC[k]);
        expErr  = expDone && mOdd[k];
        expData = (expDone && !mOdd[k]) ? mem[k][mWord[k]] : 16'h0000;
        checkOutput("done",  k, 16'(done[k]),  16'(expDone));
        checkOutput("busy",  k, 16'(busy[k]),  16'(expBusy));
        checkOutput("err",   k, 16'(err[k]),   16'(expErr));
        checkOutput("stall", k, 16'(stall[k]), 16'(en[k] && !expDone));
        if (!expDone || !mWr[k]) checkOutput("dout", k, dout[k], expData);
      end
    end
    for (int k = 0; k < NI; k++) begin
      if (rst[k] === 1'b0) begin
        valid[k]   = 1;
        acceptC[k] = -1;
        doneC[k]   = -1;
        for (int w = 0; w < 256; w++) mem[k][w] = 16'h0000;
      end else if (valid[k]) begin
        if (doneC[k] == cyc && mWr[k] && !mOdd[k]) mem[k][mWord[k]] = mData[k];
        if (doneC[k] < cyc && en[k] === 1'b1) begin
          acceptC[k] = cyc;
          doneC[k]   = cyc + latOf(k);
          mWr[k]     = wr[k];
          mOdd[k]    = addr[k][0];
          mWord[k]   = int'(addr[k][8:1]);
          mData[k]   = din[k];
        end
      end
    end
    cyc++;
  end

  // Directed scenarios with hand-computed expectations, then random traffic
  initial begin
    int          lat;
    int          stalls;
    int          dn;
    int          bz;
    int          flips;
    logic [15:0] rd;
    logic        er;
    logic        prevDone;

    for (int k = 0; k < NI; k++) begin
      rst[k]  = 1'b0;
      en[k]   = 1'b0;
      wr[k]   = 1'b0;
      addr[k] = 16'h0000;
      din[k]  = 16'h0000;
    end
    en[0]   = 1'b1;
    wr[0]   = 1'b1;
    addr[0] = 16'h0010;
    din[0]  = 16'hBEEF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstDone",  0, 16'(done[0]),  16'd0);
    checkOutput("rstBusy",  0, 16'(busy[0]),  16'd0);
    checkOutput("rstDout",  0, dout[0],       16'h0000);
    checkOutput("rstStall", 0, 16'(stall[0]), 16'd1);

    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) rst[k] = 1'b1;
    waitDone(0, lat, stalls, rd, er);
    checkOutput("wrLat",   0, 16'(lat),    16'd2);
    checkOutput("wrStall", 0, 16'(stalls), 16'd2);
    checkOutput("wrErr",   0, 16'(er),     16'd0);
    @(posedge clk);
    #1;
    en[0] = 1'b0;

    applyStimulus(0, 1'b0, 16'h0010, 16'h0000, lat, stalls, rd, er);
    checkOutput("rdData",  0, rd,           16'hBEEF);
    checkOutput("rdLat",   0, 16'(lat),     16'd2);
    checkOutput("rdStall", 0, 16'(stalls),  16'd2);

    applyStimulus(0, 1'b1, 16'h0011, 16'h1234, lat, stalls, rd, er);
    checkOutput("oddErr",  0, 16'(er), 16'd1);
    checkOutput("oddDout", 0, rd,      16'h0000);
    applyStimulus(0, 1'b0, 16'h0010, 16'h0000, lat, stalls, rd, er);
    checkOutput("oddKeep", 0, rd, 16'hBEEF);

    @(posedge clk);
    #1;
    en[0]   = 1'b1;
    wr[0]   = 1'b1;
    addr[0] = 16'h0030;
    din[0]  = 16'h5555;
    @(posedge clk);
    #1;
    wr[0]   = 1'b0;
    addr[0] = 16'h0040;
    din[0]  = 16'h6666;
    waitDone(0, lat, stalls, rd, er);
    checkOutput("capLat", 0, 16'(lat), 16'd1);
    @(posedge clk);
    #1;
    en[0] = 1'b0;
    applyStimulus(0, 1'b0, 16'h0030, 16'h0000, lat, stalls, rd, er);
    checkOutput("capOld", 0, rd, 16'h5555);
    applyStimulus(0, 1'b0, 16'h0040, 16'h0000, lat, stalls, rd, er);
    checkOutput("capNew", 0, rd, 16'h0000);

    dn       = 0;
    bz       = 0;
    flips    = 0;
    prevDone = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      en[1]   = 1'b1;
      wr[1]   = (i % 3 == 0);
      addr[1] = ((i / 2) % 2 == 0) ? 16'h0002 : 16'h0004;
      din[1]  = 16'(16'h0100 + i);
      @(negedge clk);
      if (done[1] === 1'b1) dn++;
      if (busy[1] === 1'b1) bz++;
      if (i > 0 && done[1] !== prevDone) flips++;
      prevDone = done[1];
    end
    @(posedge clk);
    #1;
    en[1] = 1'b0;
    checkOutput("b2bDone",  1, 16'(dn),    16'd5);
    checkOutput("b2bBusy",  1, 16'(bz),    16'd5);
    checkOutput("b2bFlips", 1, 16'(flips), 16'd9);

    @(posedge clk);
    #1;
    en[2]   = 1'b1;
    wr[2]   = 1'b1;
    addr[2] = 16'h0020;
    din[2]  = 16'hAAAA;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    en[2]  = 1'b0;
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done[2] === 1'b1) dn++;
      @(posedge clk);
      #1;
    end
    checkOutput("abortDone", 2, 16'(dn), 16'd0);
    applyStimulus(2, 1'b0, 16'h0020, 16'h0000, lat, stalls, rd, er);
    checkOutput("abortData",  2, rd,          16'h0000);
    checkOutput("abortLat",   2, 16'(lat),    16'd4);
    checkOutput("abortStall", 2, 16'(stalls), 16'd4);
    applyStimulus(2, 1'b1, 16'h0020, 16'hAAAA, lat, stalls, rd, er);
    applyStimulus(2, 1'b0, 16'h0020, 16'h0000, lat, stalls, rd, er);
    checkOutput("l4Data", 2, rd, 16'hAAAA);

    repeat (400) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
        rst[k]  = ($urandom_range(0, 59) != 0);
        en[k]   = ($urandom_range(0, 9) < 7);
        wr[k]   = 1'($urandom_range(0, 1));
        addr[k] = {10'h000, 5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0)};
        din[k]  = 16'($urandom);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      en[k]  = 1'b0;
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_stall_responder.md
# dmem_stall_responder

Multi-cycle data-memory responder serving the memory stage's Enable/MemWrite request interface. It accepts one word read or write, holds the requester with Stall for a fixed, parameterised latency, then pulses Done with read data or write commit. It replaces the single-cycle data memory behind the memory stage so pipeline stall logic can be exercised against a memory that does not answer in one cycle.

## Interface
- DEPTH_LOG2, default 8: number of words is 2^DEPTH_LOG2; word index is Addr[DEPTH_LOG2:1].
- LATENCY, default 2: cycles from acceptance to Done; legal range 1..15.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-low reset (0 = reset); sampled on clk.
- Enable  input  1  request valid; held high by the requester until Done.
- Wr  input  1  1 = write, 0 = read; sampled at acceptance.
- Addr  input  16  byte address; bit 0 must be 0.
- DataIn  input  16  write data; sampled at acceptance.
- DataOut  output  16  read data; valid only while Done=1, otherwise 16'h0000.
- Done  output  1  one-cycle completion pulse, registered.
- Stall  output  1  combinational: Enable & ~Done.
- Busy  output  1  state != IDLE.
- Err  output  1  high with Done when the accepted Addr[0] was 1.

## Operation
- States: IDLE, WAIT, RESP; encoding is defined in the shared package.
- IDLE: if Enable=1, accept: capture Wr, Addr, DataIn; load cnt = LATENCY-1; go to WAIT, or directly to RESP if LATENCY=1.
- WAIT: decrement cnt each cycle; when cnt==0, go to RESP.
- RESP: Done=1 for exactly this cycle; next state is IDLE unconditionally. No request is accepted in RESP.
- Write commit: array[word] <= captured DataIn on the clock edge that ends the RESP cycle. Skipped when Err=1.
- Read: DataOut = array[captured word] during RESP. A read that follows a write to the same word sees the new value.
- Err (Addr[0]=1): Done and Err pulse together, DataOut=0, and no write is performed.
- Captured values are used throughout. Changes on Addr, Wr or DataIn after acceptance are ignored.
- If Enable drops mid-operation, the operation still completes: Done pulses and any write commits.
- Array contents: all words cleared to 0 on reset.

## Timing
- Reset (rst=0 at an edge): state=IDLE, cnt=0; Done=0, Err=0, Busy=0, DataOut=0. Stall follows Enable during reset.
- Reset mid-operation: the operation is aborted, no write commits, and Done does not pulse.
- Acceptance in cycle t (IDLE, Enable=1) gives Busy=1 from t+1 and Done=1 in cycle t+LATENCY.
- The earliest next acceptance is cycle t+LATENCY+1, which gives a throughput of one request per LATENCY+1 cycles.
- Stall is high during the acceptance cycle and all WAIT cycles, and low in the Done cycle.
- A requester holding Enable continuously is re-accepted in the cycle after RESP, so each held cycle issues a new request.

## Structure
- Package dmem_pkg: the state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), the default LATENCY, and the default DEPTH_LOG2.
- One sub-module, dmem_array: a synchronous-write, combinational-read word array with synchronous clear. The responder FSM and countdown counter live in the top module.

## Test plan
- Reset: hold rst=0 for 2 cycles with Enable=1 -> Done=0, Busy=0, DataOut=0, Stall=1. Then rst=1 -> request accepted on the next cycle.
- Write then read, LATENCY=2: write Addr=16'h0010, DataIn=16'hBEEF -> Done in cycle t+2 with Err=0. Then read 16'h0010 -> DataOut=16'hBEEF with Done; Stall=1 for exactly 2 cycles per request.
- LATENCY=1 back-to-back: Enable held with alternating addresses -> Done every 2nd cycle, Busy toggling 1/0.
- Unaligned access: write Addr=16'h0011, DataIn=16'h1234 -> Done=1 and Err=1, no write. A read of 16'h0010 then returns the previous value.
- Input change after acceptance: change Addr and DataIn in the cycle after acceptance -> the originally captured address and data are written.
- Reset mid-WAIT with LATENCY=4: write 16'hAAAA to 16'h0020, assert rst=0 during cnt=2 -> no Done pulse, and a read of 16'h0020 afterwards returns 16'h0000.
